// File: rtl/ccd_scan_averager_if.sv
// Signals between the ADC capture block, the scan averager and the host readout path.
// The capture/host side drives through master; the averager uses slave.
interface ccd_scan_averager_if #(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned MAX_AVG_LOG2 = 4
);
   logic                  acq_start;
   logic [2:0]            avg_log2;
   logic                  pix_valid;
   logic [DATA_W-1:0]     pix_data;
   logic                  rd_en;
   logic [DATA_W-1:0]     rd_data;
   logic                  rd_valid;
   logic                  pixel_ready;
   logic                  busy;
   logic [MAX_AVG_LOG2:0] scan_idx;
   logic                  drop_err;

   modport master (
      output acq_start, avg_log2, pix_valid, pix_data, rd_en,
      input  rd_data, rd_valid, pixel_ready, busy, scan_idx, drop_err
   );

   modport slave (
      input  acq_start, avg_log2, pix_valid, pix_data, rd_en,
      output rd_data, rd_valid, pixel_ready, busy, scan_idx, drop_err
   );
endinterface

// File: rtl/ccd_scan_averager.sv
// Accumulates 2^navg_log2 CCD scans per pixel in a dual-port buffer and
// serves the per-pixel floor mean to the host, one pixel per rd_en.
module ccd_scan_averager #(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned PIXELS       = 2048,
   parameter int unsigned ADDR_W       = 11,
   parameter int unsigned MAX_AVG_LOG2 = 4,
   parameter int unsigned ACC_W        = DATA_W + MAX_AVG_LOG2
) (
   input logic                sys_clk,
   input logic                sys_rst,
   ccd_scan_averager_if.slave bus
);
   localparam int unsigned       SW      = MAX_AVG_LOG2 + 1;
   localparam logic [2:0]        MaxAvg  = 3'(MAX_AVG_LOG2);
   localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(PIXELS - 1);

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e            state_q, state_d;
   logic [2:0]        navg_q, navg_d;
   logic [ADDR_W-1:0] pix_idx_q, pix_idx_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [SW-1:0]     scan_q, scan_d;
   logic [SW-1:0]     target;
   logic              drop_q, drop_d;
   logic              accept, rd_acc;

   logic              wr_pend_q, wr_first_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_sample_q;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_hold_q, rd_data, mean;

   logic [ACC_W-1:0]  mem [PIXELS];
   logic [ACC_W-1:0]  mem_q, wr_val;
   logic [ADDR_W-1:0] raddr;

   assign target = SW'(1) << navg_q;

   always_comb begin
      state_d   = state_q;
      navg_d    = navg_q;
      pix_idx_d = pix_idx_q;
      rd_ptr_d  = rd_ptr_q;
      scan_d    = scan_q;
      drop_d    = drop_q;
      accept    = 1'b0;
      rd_acc    = 1'b0;
      if (bus.acq_start) begin
         // Restart wins over any coincident sample or read request.
         state_d   = StAccum;
         navg_d    = (bus.avg_log2 > MaxAvg) ? MaxAvg : bus.avg_log2;
         pix_idx_d = '0;
         rd_ptr_d  = '0;
         scan_d    = '0;
         drop_d    = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: ;
            StAccum: begin
               // Final write commits this cycle; no further samples belong to the frame.
               if (scan_q == target) begin
                  state_d  = StDone;
                  rd_ptr_d = '0;
               end else begin
                  accept = bus.pix_valid;
               end
            end
            StDone: begin
               rd_acc = bus.rd_en;
               if (rd_acc) begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
                  if (rd_ptr_q == LastPix) begin
                     state_d  = StIdle;
                     rd_ptr_d = '0;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
         if (accept) begin
            if (pix_idx_q == LastPix) begin
               pix_idx_d = '0;
               scan_d    = scan_q + 1'b1;
            end else begin
               pix_idx_d = pix_idx_q + 1'b1;
            end
         end
         if (bus.pix_valid && !accept) drop_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= StIdle;
         navg_q      <= '0;
         pix_idx_q   <= '0;
         rd_ptr_q    <= '0;
         scan_q      <= '0;
         drop_q      <= 1'b0;
         wr_pend_q   <= 1'b0;
         wr_first_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_sample_q <= '0;
         rd_valid_q  <= 1'b0;
         rd_hold_q   <= '0;
      end else begin
         state_q     <= state_d;
         navg_q      <= navg_d;
         pix_idx_q   <= pix_idx_d;
         rd_ptr_q    <= rd_ptr_d;
         scan_q      <= scan_d;
         drop_q      <= drop_d;
         wr_pend_q   <= accept;
         wr_first_q  <= (scan_q == '0);
         wr_addr_q   <= pix_idx_q;
         wr_sample_q <= bus.pix_data;
         rd_valid_q  <= rd_acc;
         rd_hold_q   <= rd_data;
      end
   end

   // Read half of the RMW happens in the sample cycle; the sum is written one cycle later.
   assign raddr  = (state_q == StDone) ? rd_ptr_q : pix_idx_q;
   assign wr_val = wr_first_q ? ACC_W'(wr_sample_q) : mem_q + ACC_W'(wr_sample_q);

   always_ff @(posedge sys_clk) begin
      if (wr_pend_q) mem[wr_addr_q] <= wr_val;
      mem_q <= mem[raddr];
   end

   assign mean    = DATA_W'(mem_q >> navg_q);
   assign rd_data = rd_valid_q ? mean : rd_hold_q;

   assign bus.rd_data     = rd_data;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.pixel_ready = (state_q == StDone);
   assign bus.busy        = (state_q == StAccum);
   assign bus.scan_idx    = scan_q;
   assign bus.drop_err    = drop_q;
endmodule

// File: tb/tb_ccd_scan_averager.sv
// Scoreboard bench for ccd_scan_averager: readout expectations are queued when rd_en
// is driven and checked by a monitor when rd_valid appears.
module tb_ccd_scan_averager;
   localparam int DATA_W       = 16;
   localparam int PIXELS       = 2048;
   localparam int ADDR_W       = 11;
   localparam int MAX_AVG_LOG2 = 4;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   always #5 sys_clk = ~sys_clk;

   ccd_scan_averager_if #(.DATA_W(DATA_W), .MAX_AVG_LOG2(MAX_AVG_LOG2)) bus ();

   ccd_scan_averager #(
      .DATA_W(DATA_W), .PIXELS(PIXELS), .ADDR_W(ADDR_W), .MAX_AVG_LOG2(MAX_AVG_LOG2)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];
   bit exp_rv = 1'b0;
   bit rv_due;

   // Sample generators: 0 ramp, 1 per-scan constants, 2 full scale, 3 stale, 4 ramp+scan
   function automatic logic [15:0] sample(input int mode, input int scan, input int i);
      case (mode)
         0: return 16'(i);
         1: return (scan == 0) ? 16'd100 : (scan == 1) ? 16'd101 : (scan == 2) ? 16'd102 : 16'd105;
         2: return 16'hFFFF;
         3: return 16'h1234 ^ 16'(i);
         default: return 16'(i * 7 + scan * 13);
      endcase
   endfunction

   function automatic logic [15:0] expect_val(input int mode, input int k, input int i);
      longint sum = 0;
      for (int s = 0; s < (1 << k); s++) sum += longint'(sample(mode, s, i));
      return 16'(sum >> k);
   endfunction

   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) rv_due <= 1'b0;
      else         rv_due <= exp_rv;
   end

   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         logic [15:0] e;
         total++;
         if (bus.rd_valid !== rv_due) begin
            bad++;
            $display("FAIL rd_valid_timing: got %b want %b at %0t", bus.rd_valid, rv_due, $time);
         end
         if (bus.rd_valid === 1'b1 && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (bus.rd_data !== e) begin
               bad++;
               $display("FAIL rd_data: got %h want %h at %0t", bus.rd_data, e, $time);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic start_acq(input logic [2:0] k);
      bus.acq_start = 1'b1;
      bus.avg_log2  = k;
      cyc();
      bus.acq_start = 1'b0;
   endtask

   task automatic feed_scan(input int mode, input int scan, input int npix, input bit gaps);
      for (int i = 0; i < npix; i++) begin
         bus.pix_valid = 1'b1;
         bus.pix_data  = sample(mode, scan, i);
         cyc();
         if (gaps && (i % 5 == 0)) begin
            bus.pix_valid = 1'b0;
            cyc();
         end
      end
      bus.pix_valid = 1'b0;
   endtask

   task automatic read_pixels(input int mode, input int k, input int n);
      for (int i = 0; i < n; i++) begin
         bus.rd_en = 1'b1;
         exp_rv    = 1'b1;
         exp_q.push_back(expect_val(mode, k, i));
         cyc();
      end
      bus.rd_en = 1'b0;
      exp_rv    = 1'b0;
   endtask

   task automatic check_drained(input string name);
      cyc();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s: %0d readouts missing, want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      bus.acq_start = 1'b0; bus.avg_log2 = '0; bus.pix_valid = 1'b0;
      bus.pix_data = '0; bus.rd_en = 1'b0;
      sys_rst = 1'b1;
      cyc(); cyc();
      total += 6;
      if (bus.rd_data !== 16'h0)     begin bad++; $display("FAIL rst_rd_data: got %h want 0", bus.rd_data); end
      if (bus.rd_valid !== 1'b0)     begin bad++; $display("FAIL rst_rd_valid: got %b want 0", bus.rd_valid); end
      if (bus.pixel_ready !== 1'b0)  begin bad++; $display("FAIL rst_pixel_ready: got %b want 0", bus.pixel_ready); end
      if (bus.busy !== 1'b0)         begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
      if (bus.scan_idx !== 5'd0)     begin bad++; $display("FAIL rst_scan_idx: got %0d want 0", bus.scan_idx); end
      if (bus.drop_err !== 1'b0)     begin bad++; $display("FAIL rst_drop_err: got %b want 0", bus.drop_err); end
      sys_rst = 1'b0;
      cyc();
   endtask

   task automatic test_single_scan();
      start_acq(3'd0);
      feed_scan(0, 0, PIXELS, 1'b0);
      total += 2;
      if (bus.pixel_ready !== 1'b0) begin bad++; $display("FAIL ready_early: got %b want 0", bus.pixel_ready); end
      if (bus.busy !== 1'b1)        begin bad++; $display("FAIL busy_commit: got %b want 1", bus.busy); end
      cyc();
      total += 3;
      if (bus.pixel_ready !== 1'b1) begin bad++; $display("FAIL ready_set: got %b want 1", bus.pixel_ready); end
      if (bus.busy !== 1'b0)        begin bad++; $display("FAIL busy_done: got %b want 0", bus.busy); end
      if (bus.scan_idx !== 5'd1)    begin bad++; $display("FAIL scan_idx_1: got %0d want 1", bus.scan_idx); end
      read_pixels(0, 0, PIXELS);
      total++;
      if (bus.pixel_ready !== 1'b0) begin bad++; $display("FAIL ready_clear: got %b want 0", bus.pixel_ready); end
      check_drained("single_scan_drain");
      // Back in idle: further reads must produce nothing (monitor expects rd_valid=0).
      bus.rd_en = 1'b1; cyc(); cyc(); bus.rd_en = 1'b0; cyc();
   endtask

   task automatic test_drop_idle();
      bus.pix_valid = 1'b1; bus.pix_data = 16'hBEEF;
      cyc();
      bus.pix_valid = 1'b0;
      total += 2;
      if (bus.drop_err !== 1'b1) begin bad++; $display("FAIL drop_idle: got %b want 1", bus.drop_err); end
      if (bus.busy !== 1'b0)     begin bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_avg4();
      start_acq(3'd2);
      total += 3;
      if (bus.drop_err !== 1'b0) begin bad++; $display("FAIL drop_clear: got %b want 0", bus.drop_err); end
      if (bus.busy !== 1'b1)     begin bad++; $display("FAIL busy_start: got %b want 1", bus.busy); end
      if (bus.scan_idx !== 5'd0) begin bad++; $display("FAIL scan_idx_start: got %0d want 0", bus.scan_idx); end
      for (int s = 0; s < 4; s++) feed_scan(1, s, PIXELS, 1'b1);
      cyc(); cyc();
      total += 2;
      if (bus.scan_idx !== 5'd4)    begin bad++; $display("FAIL scan_idx_4: got %0d want 4", bus.scan_idx); end
      if (bus.pixel_ready !== 1'b1) begin bad++; $display("FAIL ready_avg4: got %b want 1", bus.pixel_ready); end
      read_pixels(1, 2, PIXELS);
      check_drained("avg4_drain");
   endtask

   task automatic test_clamp_and_drop_done();
      start_acq(3'd7);
      for (int s = 0; s < 16; s++) feed_scan(2, s, PIXELS, 1'b0);
      cyc();
      total += 2;
      if (bus.scan_idx !== 5'd16)   begin bad++; $display("FAIL scan_idx_16: got %0d want 16", bus.scan_idx); end
      if (bus.pixel_ready !== 1'b1) begin bad++; $display("FAIL ready_clamp: got %b want 1", bus.pixel_ready); end
      for (int i = 0; i < 3; i++) begin
         bus.pix_valid = 1'b1; bus.pix_data = 16'h0000; cyc();
      end
      bus.pix_valid = 1'b0;
      total += 2;
      if (bus.drop_err !== 1'b1)    begin bad++; $display("FAIL drop_done: got %b want 1", bus.drop_err); end
      if (bus.pixel_ready !== 1'b1) begin bad++; $display("FAIL ready_after_drop: got %b want 1", bus.pixel_ready); end
      read_pixels(2, 4, 500);
      #5;
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL pre_reset_drain: got %0d want 0", exp_q.size()); end
      // Asynchronous reset mid-cycle while a frame is half read.
      #2 sys_rst = 1'b1;
      #1;
      total += 5;
      if (bus.rd_data !== 16'h0)    begin bad++; $display("FAIL midrst_rd_data: got %h want 0", bus.rd_data); end
      if (bus.rd_valid !== 1'b0)    begin bad++; $display("FAIL midrst_rd_valid: got %b want 0", bus.rd_valid); end
      if (bus.pixel_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b want 0", bus.pixel_ready); end
      if (bus.drop_err !== 1'b0)    begin bad++; $display("FAIL midrst_drop: got %b want 0", bus.drop_err); end
      if (bus.scan_idx !== 5'd0)    begin bad++; $display("FAIL midrst_scan_idx: got %0d want 0", bus.scan_idx); end
      cyc();
      sys_rst = 1'b0;
      bus.rd_en = 1'b1; cyc(); cyc(); cyc(); bus.rd_en = 1'b0; cyc();
   endtask

   task automatic test_abort();
      start_acq(3'd1);
      feed_scan(3, 0, PIXELS, 1'b0);
      feed_scan(3, 1, 1000, 1'b0);
      // Restart coincides with pixel 1000 of scan 1; the sample must be discarded.
      bus.acq_start = 1'b1; bus.avg_log2 = 3'd1;
      bus.pix_valid = 1'b1; bus.pix_data = 16'hDEAD;
      cyc();
      bus.acq_start = 1'b0; bus.pix_valid = 1'b0;
      total += 4;
      if (bus.pixel_ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", bus.pixel_ready); end
      if (bus.scan_idx !== 5'd0)    begin bad++; $display("FAIL abort_scan_idx: got %0d want 0", bus.scan_idx); end
      if (bus.drop_err !== 1'b0)    begin bad++; $display("FAIL abort_drop: got %b want 0", bus.drop_err); end
      if (bus.busy !== 1'b1)        begin bad++; $display("FAIL abort_busy: got %b want 1", bus.busy); end
      feed_scan(4, 0, PIXELS, 1'b0);
      feed_scan(4, 1, PIXELS, 1'b1);
      cyc(); cyc();
      total++;
      if (bus.pixel_ready !== 1'b1) begin bad++; $display("FAIL abort_ready_final: got %b want 1", bus.pixel_ready); end
      read_pixels(4, 1, PIXELS);
      check_drained("abort_drain");
   endtask

   initial begin
      test_reset();
      test_single_scan();
      test_drop_idle();
      test_avg4();
      test_clamp_and_drop_done();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
